// File: rtl/core_mem_pkg.sv
// Shared encodings for the core memory path: access direction and burst FSM states.
package core_mem_pkg;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    LAST = 2'd3
  } state_e;

endpackage

// File: rtl/core_memory_burst_controller.sv
// Splits an arbiter burst into BURST_LEN single-word req/ack accesses; Req one cycle after
// acceptance, beat strobe one cycle after each ack; the backing memory stalls via a held Req.
module core_memory_burst_controller
  import core_mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 21,
  parameter int BURST_LEN     = 4
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_MEM_Valid,
  input  logic [ADDRESS_WIDTH-1:0] i_MEM_Address,
  input  logic                     i_MEM_Read_Write_n,
  input  logic [DATA_WIDTH-1:0]    i_MEM_Data,
  output logic                     o_MEM_Valid,
  output logic [DATA_WIDTH-1:0]    o_MEM_Data,
  output logic                     o_MEM_Data_Read,
  output logic                     o_MEM_Last,
  output logic                     o_RAM_Req,
  output logic                     o_RAM_We,
  output logic [ADDRESS_WIDTH-1:0] o_RAM_Addr,
  output logic [DATA_WIDTH-1:0]    o_RAM_WData,
  input  logic                     i_RAM_Ack,
  input  logic [DATA_WIDTH-1:0]    i_RAM_RData
);

  localparam int BEAT_BITS = $clog2(BURST_LEN);
  localparam int BASE_BITS = ADDRESS_WIDTH - BEAT_BITS;

  state_e                 state_q, state_d;
  logic [BEAT_BITS-1:0]   beat_q, beat_d;
  logic                   rw_n_q, rw_n_d;
  logic [BASE_BITS-1:0]   base_q, base_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

  // Beat offset bits of the request address are deliberately dropped.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^i_MEM_Address[BEAT_BITS-1:0];

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      rw_n_q  <= READ;
      base_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rw_n_q  <= rw_n_d;
      base_q  <= base_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    rw_n_d  = rw_n_q;
    base_d  = base_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (i_MEM_Valid) begin
          rw_n_d  = i_MEM_Read_Write_n;
          base_d  = i_MEM_Address[ADDRESS_WIDTH-1:BEAT_BITS];
          beat_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (i_RAM_Ack) begin
          if (rw_n_q == READ) rdata_d = i_RAM_RData;
          // BURST_LEN is a power of two, so an all-ones beat is the final one.
          state_d = (&beat_q) ? LAST : RESP;
        end
      end
      RESP: begin
        beat_d  = beat_q + 1'b1;
        state_d = REQ;
      end
      LAST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_RAM_Req       = 1'b0;
    o_RAM_We        = 1'b0;
    o_RAM_Addr      = '0;
    o_MEM_Valid     = 1'b0;
    o_MEM_Data_Read = 1'b0;
    o_MEM_Last      = 1'b0;
    case (state_q)
      REQ: begin
        o_RAM_Req  = 1'b1;
        o_RAM_We   = (rw_n_q == WRITE);
        o_RAM_Addr = {base_q, beat_q};
      end
      RESP, LAST: begin
        o_MEM_Valid     = (rw_n_q == READ);
        o_MEM_Data_Read = (rw_n_q == WRITE);
        o_MEM_Last      = (state_q == LAST);
      end
      default: ;
    endcase
  end

  assign o_MEM_Data  = rdata_q;
  assign o_RAM_WData = i_MEM_Data;

endmodule

// File: tb/tb_core_memory_burst_controller.sv
// Scoreboarded bench for the burst controller with a req/ack memory responder.
module tb_core_memory_burst_controller;

  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic        i_MEM_Valid;
  logic [20:0] i_MEM_Address;
  logic        i_MEM_Read_Write_n;
  logic [31:0] i_MEM_Data;
  logic        o_MEM_Valid;
  logic [31:0] o_MEM_Data;
  logic        o_MEM_Data_Read;
  logic        o_MEM_Last;
  logic        o_RAM_Req;
  logic        o_RAM_We;
  logic [20:0] o_RAM_Addr;
  logic [31:0] o_RAM_WData;
  logic        i_RAM_Ack;
  logic [31:0] i_RAM_RData;

  core_memory_burst_controller #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(21), .BURST_LEN(4)
  ) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset),
    .i_MEM_Valid(i_MEM_Valid), .i_MEM_Address(i_MEM_Address),
    .i_MEM_Read_Write_n(i_MEM_Read_Write_n), .i_MEM_Data(i_MEM_Data),
    .o_MEM_Valid(o_MEM_Valid), .o_MEM_Data(o_MEM_Data),
    .o_MEM_Data_Read(o_MEM_Data_Read), .o_MEM_Last(o_MEM_Last),
    .o_RAM_Req(o_RAM_Req), .o_RAM_We(o_RAM_We), .o_RAM_Addr(o_RAM_Addr),
    .o_RAM_WData(o_RAM_WData), .i_RAM_Ack(i_RAM_Ack), .i_RAM_RData(i_RAM_RData)
  );

  always #5 i_Clk = ~i_Clk;

  int checks = 0;
  int failures = 0;

  logic [20:0] exp_addr[$];
  logic        exp_we[$];
  logic [31:0] exp_wd[$];
  logic [32:0] exp_rd[$];
  logic        exp_wl[$];

  logic [31:0] wdat[4];
  int          wr_idx;
  int          cyc = 0;
  int          req_cnt, last_cnt, first_req_cyc, last_cyc;
  int          dly_beat, dly_n, wait_cnt;
  logic        prev_req = 1'b0;
  logic [20:0] held_addr;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: observe the DUT at the falling edge, then act as the memory and upstream.
  task automatic step();
    logic [32:0] rd;
    logic        wl;
    @(negedge i_Clk);
    cyc++;
    if (o_MEM_Valid && o_MEM_Data_Read) chk("strobe_excl", 1, 0);
    if (o_MEM_Valid) begin
      if (exp_rd.size() == 0) chk("unexp_valid", 1, 0);
      else begin
        rd = exp_rd.pop_front();
        chk("rdata", 64'(o_MEM_Data), 64'(rd[31:0]));
        chk("rlast", 64'(o_MEM_Last), 64'(rd[32]));
      end
    end
    if (o_MEM_Data_Read) begin
      if (exp_wl.size() == 0) chk("unexp_dread", 1, 0);
      else begin
        wl = exp_wl.pop_front();
        chk("wlast", 64'(o_MEM_Last), 64'(wl));
      end
      wr_idx++;
    end
    if (o_MEM_Last) begin
      last_cnt++;
      last_cyc = cyc;
    end
    i_RAM_Ack = 1'b0;
    if (o_RAM_Req) begin
      if (o_MEM_Valid || o_MEM_Data_Read) chk("strobe_in_req", 1, 0);
      if (!prev_req) begin
        req_cnt++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
        wait_cnt = (req_cnt - 1 == dly_beat) ? dly_n : 0;
        held_addr = o_RAM_Addr;
        if (exp_addr.size() == 0) chk("unexp_req", 1, 0);
        else begin
          chk("ram_addr", 64'(o_RAM_Addr), 64'(exp_addr.pop_front()));
          chk("ram_we", 64'(o_RAM_We), 64'(exp_we.pop_front()));
          if (o_RAM_We) chk("ram_wdata", 64'(o_RAM_WData), 64'(exp_wd[0]));
          void'(exp_wd.pop_front());
        end
      end else begin
        chk("addr_stable", 64'(o_RAM_Addr), 64'(held_addr));
      end
      if (wait_cnt == 0) begin
        i_RAM_Ack   = 1'b1;
        i_RAM_RData = 32'hA0 + 32'(o_RAM_Addr[1:0]);
      end else begin
        wait_cnt--;
      end
    end
    prev_req   = o_RAM_Req;
    i_MEM_Data = wdat[(wr_idx > 3) ? 3 : wr_idx];
  endtask

  task automatic run_burst(input logic [20:0] addr, input logic rw, input int delay_beat,
                           input int delay_n, input int span, input bit drop_valid,
                           input bit keep_valid, input logic [20:0] next_addr,
                           input int stop_at_req);
    logic [20:0] base;
    bit done;
    base = {addr[20:2], 2'b00};
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(base + 21'(i));
      exp_we.push_back(!rw);
      exp_wd.push_back(wdat[i]);
      if (rw) exp_rd.push_back({(i == 3), 32'hA0 + 32'(i)});
      else    exp_wl.push_back(i == 3);
    end
    wr_idx = 0;
    i_MEM_Data = wdat[0];
    i_MEM_Valid = 1'b1;
    i_MEM_Address = addr;
    i_MEM_Read_Write_n = rw;
    req_cnt = 0;
    last_cnt = 0;
    first_req_cyc = -1;
    dly_beat = delay_beat;
    dly_n = delay_n;
    done = 0;
    for (int n = 0; n < 200; n++) begin
      step();
      if (drop_valid && req_cnt >= 2) begin
        i_MEM_Valid = 1'b0;
        i_MEM_Address = '1;
        i_MEM_Read_Write_n = !rw;
      end
      if (stop_at_req != 0 && req_cnt == stop_at_req) return;
      if (last_cnt > 0) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("burst_timeout", 0, 1);
    if (span > 0) chk("span", 64'(last_cyc - first_req_cyc + 1), 64'(span));
    if (keep_valid) begin
      i_MEM_Address = next_addr;
      i_MEM_Read_Write_n = 1'b1;
    end else begin
      i_MEM_Valid = 1'b0;
    end
  endtask

  task automatic settle();
    for (int i = 0; i < 3; i++) step();
    chk("last_once", 64'(last_cnt), 1);
    chk("sb_empty", 64'(exp_addr.size() + exp_rd.size() + exp_wl.size()), 0);
  endtask

  initial begin
    int l_prev;
    i_Reset = 1'b1;
    i_MEM_Valid = 1'b0;
    i_MEM_Address = '0;
    i_MEM_Read_Write_n = 1'b1;
    i_MEM_Data = '0;
    i_RAM_Ack = 1'b0;
    i_RAM_RData = '0;
    wdat = '{32'h11, 32'h22, 32'h33, 32'h44};
    dly_beat = -1;
    dly_n = 0;
    wait_cnt = 0;
    wr_idx = 0;
    last_cnt = 0;
    repeat (3) @(negedge i_Clk);
    chk("reset_ctl", {o_RAM_Req, o_RAM_We, o_MEM_Valid, o_MEM_Data_Read, o_MEM_Last}, 0);
    chk("reset_addr", 64'(o_RAM_Addr), 0);
    chk("reset_data", 64'(o_MEM_Data), 0);
    i_Reset = 1'b0;

    // Zero-wait read burst.
    run_burst(21'h000100, 1'b1, -1, 0, 8, 0, 0, '0, 0);
    settle();

    // Write burst with unaligned base.
    run_burst(21'h000207, 1'b0, -1, 0, 8, 0, 0, '0, 0);
    settle();

    // Read with beat 2 acked five cycles late.
    run_burst(21'h000100, 1'b1, 2, 5, 13, 0, 0, '0, 0);
    settle();

    // Back-to-back: valid held through LAST, next request at 0x300.
    run_burst(21'h000100, 1'b1, -1, 0, 8, 0, 1, 21'h000300, 0);
    l_prev = last_cyc;
    run_burst(21'h000300, 1'b1, -1, 0, 8, 0, 0, '0, 0);
    chk("b2b_gap", 64'(first_req_cyc - l_prev), 2);
    settle();

    // Reset while beat 1 waits on its ack.
    run_burst(21'h000100, 1'b1, 1, 3, 0, 0, 0, '0, 2);
    i_Reset = 1'b1;
    i_MEM_Valid = 1'b0;
    @(negedge i_Clk);
    chk("midrst_ctl", {o_RAM_Req, o_RAM_We, o_MEM_Valid, o_MEM_Data_Read, o_MEM_Last}, 0);
    chk("midrst_addr", 64'(o_RAM_Addr), 0);
    chk("midrst_data", 64'(o_MEM_Data), 0);
    i_Reset = 1'b0;
    prev_req = 1'b0;
    exp_addr.delete(); exp_we.delete(); exp_wd.delete(); exp_rd.delete(); exp_wl.delete();
    @(negedge i_Clk);
    chk("midrst_nolast", {o_RAM_Req, o_MEM_Last}, 0);
    run_burst(21'h000104, 1'b1, -1, 0, 8, 0, 0, '0, 0);
    settle();

    // Spurious ack in IDLE, then valid dropped mid-burst.
    @(negedge i_Clk);
    i_RAM_Ack = 1'b1;
    i_RAM_RData = 32'hDEAD;
    @(negedge i_Clk);
    i_RAM_Ack = 1'b0;
    chk("spur_ack", {o_RAM_Req, o_MEM_Valid, o_MEM_Data_Read, o_MEM_Last}, 0);
    run_burst(21'h000208, 1'b1, -1, 0, 8, 1, 0, '0, 0);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
